// File: rtl/vga_pixel_fetch.sv
// Pixel prefetcher for the VGA driver: reads frame memory ahead of the raster into a small FIFO
// and hands one 12-bit RGB word to the driver per pix_rd strobe, realigning on every frame_start.
module vga_pixel_fetch #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned ADDR_W      = 19,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter logic [11:0] UFLOW_COLOR = 12'h000
) (
    input  logic                          clk25MHz,
    input  logic                          rst_n,
    input  logic                          frame_start,
    input  logic                          pix_rd,
    output logic [11:0]                   pix_data,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_gnt,
    input  logic                          mem_rvalid,
    input  logic [11:0]                   mem_rdata,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W    = PTR_W + 1;
    localparam int unsigned SUM_W    = LVL_W + 1;
    localparam int unsigned LAST_PIX = H_ACTIVE * V_ACTIVE - 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t             state;
    logic [LVL_W-1:0]   outstanding;
    logic [LVL_W-1:0]   stale;
    logic [LVL_W-1:0]   outstanding_nx;
    logic [LVL_W-1:0]   stale_nx;
    logic [SUM_W-1:0]   in_flight;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [11:0]        fifo_mem [FIFO_DEPTH];

    logic accept;
    logic rsp_stale;
    logic rsp_live;
    logic fifo_empty;
    logic push;
    logic pop;

    // Credit check: FIFO slots already filled plus reads still owed must leave room for one more.
    assign mem_req = (state == RUN) &&
                     ((SUM_W'(fifo_level) + SUM_W'(outstanding)) < SUM_W'(FIFO_DEPTH));

    assign accept     = mem_req && mem_gnt;
    assign rsp_stale  = mem_rvalid && (stale != '0);
    assign rsp_live   = mem_rvalid && (stale == '0) && (outstanding != '0);
    assign fifo_empty = (fifo_level == '0);
    assign push       = rsp_live && !frame_start;
    assign pop        = pix_rd && !frame_start && !fifo_empty;

    // Everything still owed by memory after this edge; on frame_start it all becomes stale.
    assign in_flight = SUM_W'(stale) + SUM_W'(outstanding) + SUM_W'(accept)
                     - SUM_W'(rsp_stale || rsp_live);

    always_comb begin
        stale_nx       = stale;
        outstanding_nx = outstanding;
        if (frame_start) begin
            stale_nx       = LVL_W'(in_flight);
            outstanding_nx = '0;
        end else begin
            if (rsp_stale) begin
                stale_nx = stale - LVL_W'(1);
            end
            if (accept && !rsp_live) begin
                outstanding_nx = outstanding + LVL_W'(1);
            end else if (!accept && rsp_live) begin
                outstanding_nx = outstanding - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pix_data    <= '0;
            mem_addr    <= '0;
            underflow   <= 1'b0;
            fifo_level  <= '0;
            outstanding <= '0;
            stale       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding_nx;
            stale       <= stale_nx;
            if (frame_start) begin
                state      <= (stale_nx != '0) ? FLUSH : RUN;
                fifo_level <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                mem_addr   <= '0;
                underflow  <= 1'b0;
            end else begin
                if (state == FLUSH && stale_nx == '0) begin
                    state <= RUN;
                end
                // Prefetch runs straight through blanking into the next frame's pixel 0.
                if (accept) begin
                    mem_addr <= (mem_addr == ADDR_W'(LAST_PIX)) ? '0 : mem_addr + ADDR_W'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr   <= rd_ptr + PTR_W'(1);
                    pix_data <= fifo_mem[rd_ptr];
                end else if (pix_rd && fifo_empty) begin
                    pix_data  <= UFLOW_COLOR;
                    underflow <= 1'b1;
                end
                fifo_level <= fifo_level + LVL_W'(push) - LVL_W'(pop);
            end
        end
    end

    always_ff @(posedge clk25MHz) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Randomised scoreboard bench for vga_pixel_fetch: a memory responder with variable latency and a
// queue-based model of the pixel stream predict every output.
module tb_vga_pixel_fetch;

    localparam int unsigned H     = 640;
    localparam int unsigned V     = 2;
    localparam int unsigned NPIX  = H * V;
    localparam int unsigned AW    = 19;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
    localparam logic [11:0] UFC   = 12'hF0F;

    logic          clk25MHz    = 1'b0;
    logic          rst_n       = 1'b0;
    logic          frame_start = 1'b0;
    logic          pix_rd      = 1'b0;
    logic          mem_gnt     = 1'b0;
    logic          mem_rvalid  = 1'b0;
    logic [11:0]   mem_rdata   = '0;
    logic [11:0]   pix_data;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          underflow;
    logic [LW-1:0] fifo_level;

    vga_pixel_fetch #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .UFLOW_COLOR(UFC)
    ) dut (
        .clk25MHz(clk25MHz), .rst_n(rst_n), .frame_start(frame_start), .pix_rd(pix_rd),
        .pix_data(pix_data), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .underflow(underflow),
        .fifo_level(fifo_level)
    );

    always #20 clk25MHz = ~clk25MHz;

    typedef struct { int epoch; int addr; longint due; } rd_t;
    typedef struct { logic [11:0] pix; bit uf; int lvl; } exp_t;

    rd_t         pend[$];
    exp_t        sb_q[$];
    logic [11:0] mq[$];
    exp_t        mon_e;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cur_epoch   = 0;
    bit          started     = 1'b0;
    bit          in_rst      = 1'b1;
    int          exp_addr    = 0;
    bit          mdl_uf      = 1'b0;
    logic [11:0] mdl_pix     = '0;
    longint      cyc         = 0;
    int          lat_min     = 2;
    int          lat_max     = 2;
    int          rv_prob     = 100;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int count_cur();
        int n = 0;
        foreach (pend[i]) if (pend[i].epoch == cur_epoch) n++;
        return n;
    endfunction

    // Monitor: one expected output set per clock edge, compared on the falling edge.
    always @(negedge clk25MHz) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("pix_data",   32'(pix_data),   32'(mon_e.pix));
            chk("underflow",  32'(underflow),  32'(mon_e.uf));
            chk("fifo_level", 32'(fifo_level), 32'(mon_e.lvl));
        end
    end

    task automatic cycle(input bit fs, input bit rd, input bit gnt);
        bit   acc;
        bit   rv;
        bit   exp_req;
        int   cur_cnt;
        int   st_cnt;
        rd_t  h;
        exp_t e;
        @(negedge clk25MHz);
        #2;
        cur_cnt = count_cur();
        st_cnt  = pend.size() - cur_cnt;
        exp_req = !in_rst && started && (st_cnt == 0) && ((mq.size() + cur_cnt) < int'(DEPTH));
        chk("mem_req", 32'(mem_req), 32'(exp_req));
        frame_start = fs;
        pix_rd      = rd;
        mem_gnt     = gnt;
        acc = gnt && mem_req;
        rv  = (pend.size() > 0) && (pend[0].due <= cyc) && ($urandom_range(0, 99) < rv_prob);
        mem_rvalid = rv;
        mem_rdata  = rv ? 12'(pend[0].addr) : 12'($urandom);
        if (!in_rst) begin
            if (rd && !fs) begin
                if (mq.size() > 0) mdl_pix = mq.pop_front();
                else begin
                    mdl_pix = UFC;
                    mdl_uf  = 1'b1;
                end
            end
            if (rv) begin
                h = pend.pop_front();
                if (h.epoch == cur_epoch) mq.push_back(12'(h.addr));
            end
            if (acc) begin
                chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
                pend.push_back('{cur_epoch, int'(mem_addr),
                                 cyc + longint'($urandom_range(lat_min, lat_max))});
                exp_addr = (exp_addr + 1) % int'(NPIX);
            end
            if (fs) begin
                mq.delete();
                cur_epoch++;
                exp_addr = 0;
                mdl_uf   = 1'b0;
                started  = 1'b1;
            end
        end else if (rv) begin
            void'(pend.pop_front());
        end
        e = '{mdl_pix, mdl_uf, mq.size()};
        sb_q.push_back(e);
        cyc++;
    endtask

    task automatic model_reset();
        cur_epoch++;
        mq.delete();
        sb_q.delete();
        started  = 1'b0;
        exp_addr = 0;
        mdl_uf   = 1'b0;
        mdl_pix  = '0;
    endtask

    task automatic drain_pending();
        int guard = 0;
        while (pend.size() > 0 && guard < 300) begin
            cycle(1'b0, 1'b0, 1'b0);
            guard++;
        end
        chk("drain_timeout", 32'(pend.size()), 32'd0);
    endtask

    initial begin
        #(40 * 90000);
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        chk("rst_pix_data",   32'(pix_data),   32'd0);
        chk("rst_mem_req",    32'(mem_req),    32'd0);
        chk("rst_mem_addr",   32'(mem_addr),   32'd0);
        chk("rst_underflow",  32'(underflow),  32'd0);
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
        rst_n  = 1'b1;
        in_rst = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);

        // Fill with no reads: addresses 0..15 then request stops.
        cycle(1'b1, 1'b0, 1'b1);
        repeat (40) cycle(1'b0, 1'b0, 1'b1);
        chk("fill_level",     32'(fifo_level), 32'(DEPTH));
        chk("fill_req",       32'(mem_req),    32'd0);
        chk("fill_underflow", 32'(underflow),  32'd0);

        // Continuous reads through the address wrap.
        repeat (1400) cycle(1'b0, 1'b1, 1'b1);
        chk("stream_underflow", 32'(underflow), 32'd0);

        // Starve: 17 reads with grant withheld after refill.
        repeat (20) cycle(1'b0, 1'b0, 1'b1);
        repeat (17) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("starve_pix", 32'(pix_data),  32'(UFC));
        chk("starve_uf",  32'(underflow), 32'd1);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("fs_clears_uf", 32'(underflow), 32'd0);

        // Frame start with five reads in flight.
        lat_min = 10;
        lat_max = 10;
        repeat (5) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        chk("flush_level", 32'(fifo_level), 32'd0);
        lat_min = 2;
        lat_max = 2;
        repeat (30) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        chk("flush_first_pix", 32'(pix_data), 32'd0);

        // Randomised traffic.
        lat_min = 1;
        lat_max = 6;
        rv_prob = 70;
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 60),
                  ($urandom_range(0, 99) < 70));
        end

        // Reset with reads outstanding.
        lat_min = 8;
        lat_max = 12;
        rv_prob = 100;
        guard = 0;
        while (count_cur() < 3 && guard < 100) begin
            cycle(1'b0, 1'b0, 1'b1);
            guard++;
        end
        chk("rst_setup_outstanding", 32'(count_cur() >= 3), 32'd1);
        rst_n  = 1'b0;
        #1;
        in_rst = 1'b1;
        model_reset();
        chk("async_pix_data",   32'(pix_data),   32'd0);
        chk("async_mem_req",    32'(mem_req),    32'd0);
        chk("async_mem_addr",   32'(mem_addr),   32'd0);
        chk("async_underflow",  32'(underflow),  32'd0);
        chk("async_fifo_level", 32'(fifo_level), 32'd0);
        repeat (4) cycle(1'b0, 1'b0, 1'b1);
        rst_n  = 1'b1;
        in_rst = 1'b0;
        drain_pending();
        repeat (5) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        lat_min = 1;
        lat_max = 5;
        rv_prob = 80;
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 55), 1'b1);
        end
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
